// File: rtl/sd_dac_multi.sv
// sd_dac_multi: multi-channel sigma-delta PCM to 1-bit DAC with a sample-rate divider and a one-deep frame buffer.
// Define SD_DAC_ORDER2_EN to build second-order error-feedback modulators instead of first-order ones.
module sd_dac_multi #(
    parameter int BITDEPTH  = 12,
    parameter int CHANNELS  = 2,
    parameter int CLKDIV    = 512,
    parameter int SIGNED_IN = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [CHANNELS*BITDEPTH-1:0] pcm,
    input  logic                         pcm_valid,
    output logic                         pcm_ready,
    output logic                         sample_tick,
    output logic                         underrun,
    input  logic                         underrun_clr,
    output logic [CHANNELS-1:0]          dac_out
);
    localparam logic [15:0]          DIV_MAX = 16'(CLKDIV - 1);
    localparam logic [BITDEPTH-1:0]  MID     = {1'b1, {(BITDEPTH - 1){1'b0}}};
    localparam logic [BITDEPTH-1:0]  FLIP    = (SIGNED_IN != 0) ? MID : '0;

    logic [15:0]                  r_div_cnt;
    logic                         r_tick;
    logic                         r_pend_full;
    logic                         r_underrun;
    logic [CHANNELS*BITDEPTH-1:0] r_pending;
    logic [CHANNELS*BITDEPTH-1:0] r_active;
    logic [CHANNELS*BITDEPTH-1:0] w_conv;
    logic                         w_wrap;
    logic                         w_accept;

    assign w_wrap      = en && (r_div_cnt == DIV_MAX);
    assign w_accept    = pcm_valid && !r_pend_full;
    assign pcm_ready   = !r_pend_full;
    assign sample_tick = r_tick;
    assign underrun    = r_underrun;

    // Sample-period divider; held at zero while disabled so the first tick comes CLKDIV cycles after enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= (!en || w_wrap) ? '0 : r_div_cnt + 16'd1;
            r_tick    <= w_wrap;
        end
    end

    // One-deep pending buffer feeding the active samples; a tick with nothing pending latches underrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_full <= 1'b0;
            r_pending   <= '0;
            r_active    <= {CHANNELS{MID}};
            r_underrun  <= 1'b0;
        end else begin
            if (w_accept)
                r_pending <= w_conv;
            if (w_wrap && r_pend_full)
                r_active <= r_pending;
            r_pend_full <= w_accept | (r_pend_full & ~w_wrap);
            r_underrun  <= (w_wrap & ~r_pend_full) | (r_underrun & ~underrun_clr);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_conv[g*BITDEPTH +: BITDEPTH] = pcm[g*BITDEPTH +: BITDEPTH] ^ FLIP;
`ifdef SD_DAC_ORDER2_EN
        localparam int                   IW   = BITDEPTH + 4;
        localparam logic signed [IW+1:0] HALF = (IW + 2)'(2 ** (BITDEPTH - 1));
        localparam logic signed [IW+1:0] LIM  = (IW + 2)'(2 ** (BITDEPTH + 2));
        logic signed [IW-1:0] r_i1;
        logic signed [IW-1:0] r_i2;
        logic                 r_dac;
        logic signed [IW+1:0] w_i1;
        logic signed [IW+1:0] w_i2;
        logic signed [IW+1:0] w_x;
        logic signed [IW+1:0] w_fb;
        logic signed [IW+1:0] w_s1;
        logic signed [IW+1:0] w_s2;
        logic signed [IW+1:0] w_c1;
        logic signed [IW+1:0] w_c2;
        assign w_i1 = {{2{r_i1[IW-1]}}, r_i1};
        assign w_i2 = {{2{r_i2[IW-1]}}, r_i2};
        assign w_x  = {6'b0, r_active[g*BITDEPTH +: BITDEPTH]} - HALF;
        assign w_fb = r_dac ? HALF : -HALF;
        assign w_s1 = w_i1 + w_x - w_fb;
        assign w_s2 = w_i2 + w_i1 - w_fb;
        assign w_c1 = (w_s1 > LIM) ? LIM : ((w_s1 < -LIM) ? -LIM : w_s1);
        assign w_c2 = (w_s2 > LIM) ? LIM : ((w_s2 < -LIM) ? -LIM : w_s2);
        assign dac_out[g] = r_dac;
        // Two saturating integrators; the output bit is the sign of the updated second integrator
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_i1  <= '0;
                r_i2  <= '0;
                r_dac <= 1'b0;
            end else if (!en) begin
                r_i1  <= '0;
                r_i2  <= '0;
                r_dac <= 1'b0;
            end else begin
                r_i1  <= w_c1[IW-1:0];
                r_i2  <= w_c2[IW-1:0];
                r_dac <= !w_c2[IW+1];
            end
        end
`else
        logic [BITDEPTH:0] r_acc;
        assign dac_out[g] = r_acc[BITDEPTH];
        // First-order modulator: the carry out of the phase accumulator is the output bit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_acc <= '0;
            else
                r_acc <= en ? {1'b0, r_acc[BITDEPTH-1:0]} + {1'b0, r_active[g*BITDEPTH +: BITDEPTH]} : '0;
        end
`endif
    end
endmodule
